x_corr: RTL and testbench
=========================

Name: x_corr

Overview:
- Streaming complex cross-correlator. Multiplies each reference sample x by the conjugate of the incoming frequency-shifted sample y, and integrates the products over fixed windows of `length` samples.
- For each window it computes the squared magnitude of the window sum and tracks the running maximum and the window number where it occurred.
- One instance sits per frequency bin in the CAF engine, downstream of a freq_shift stage.

Parameters:
- xi_bits, 8: signed width of reference real sample.
- xq_bits, 8: signed width of reference imaginary sample.
- yi_bits, 8: signed width of input real sample.
- yq_bits, 8: signed width of input imaginary sample.
- i_bits, 24: signed width of real accumulator.
- q_bits, 24: signed width of imaginary accumulator.
- length, 8: samples per correlation window (≥2).
- length_counter_bits, 3: width of sample counter and window index; 2^length_counter_bits ≥ length.
- out_max_bits, 32: unsigned width of magnitude output.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- xi  in  xi_bits  reference real, signed.
- xq  in  xq_bits  reference imaginary, signed.
- yi  in  yi_bits  sample real, signed.
- yq  in  yq_bits  sample imaginary, signed.
- m_axis_tvalid  in  1  upstream sample valid.
- s_axis_tready  out  1  ready to accept sample.
- m_axis_tready  in  1  session enable from controller.
- s_axis_tvalid  out  1  one-cycle pulse: window result processed.
- out_max  out  out_max_bits  maximum window magnitude this session.
- index  out  length_counter_bits  window number of out_max.

Behaviour:
- Reset (async) values:
  - s_axis_tready=0, s_axis_tvalid=0, out_max=0, index=0.
  - Accumulators, sample counter, window counter and pipeline valids all cleared.
- Handshake:
  - s_axis_tready = m_axis_tready when not in reset (combinational).
  - A sample is accepted on a rising edge where m_axis_tvalid && s_axis_tready. No backpressure beyond m_axis_tready.
- Product, registered on the accept edge E0:
  - pi = xi*yi + xq*yq
  - pq = xq*yi − xi*yq
  - Full-precision signed; then sign-extended or truncated to i_bits / q_bits.
- Accumulation:
  - Two's-complement wrap.
  - The first product of a window loads the accumulator; later products add to it.
  - The sample counter runs 0..length−1 and wraps after the last sample.
- Window completion (last sample accepted at E0):
  - E1: the final sum is moved to the result register. If the next window's first product is valid at E1, it loads the accumulator at E1, so back-to-back windows run with no gap.
  - E2: mag = re² + im², computed unsigned at full width. If mag > 2^out_max_bits − 1, it saturates to all-ones.
  - E3:
    - If window counter = 0, or mag > out_max (strictly greater), then out_max ← mag and index ← window counter.
    - s_axis_tvalid = 1 for exactly the cycle after E3.
    - The window counter increments, wrapping at 2^length_counter_bits.
  - Ties keep the earlier index.
- m_axis_tready low:
  - Sample counter, accumulator, window counter and in-flight pipeline cleared; a partial window is discarded.
  - out_max and index hold their last values so the controller can read them.
  - A new session starts at window 0, which always overwrites out_max and index.
- Gaps in m_axis_tvalid stall accumulation without loss.
- Inputs are sampled only on accept.
- Reset mid-window clears everything immediately.

Test Plan:
- length=4, x=(1,0), y=(1,0) ×4, tready=1 → s_axis_tvalid pulse 3 cycles after the 4th accept edge; out_max=16, index=0.
- Continue with window 1 y=(2,0) ×4, then window 2 y=(1,0) ×4 → after window 1: out_max=64, index=1; after window 2: unchanged, 64/1. Windows are back-to-back with m_axis_tvalid continuously high, and pulses are spaced exactly 4 cycles apart.
- Conjugate check: x=(0,1), y=(1,0) ×4 → pq=+1 per sample, sum (0,4), out_max=16. x=(0,1), y=(0,1) ×4 → sum (4,0), out_max=16. Equal-magnitude later window keeps index 0.
- Negative values: x=(−3,0), y=(2,0) ×4 → sum (−24,0), out_max=576.
- Controls:
  - Deassert m_axis_tready after 2 samples, reassert, send 4 samples of (1,0)/(1,0) → partial window discarded; result 16 at index 0; out_max held during the low period.
  - Assert rst mid-window → all outputs 0 immediately.
- Saturation: out_max_bits=8, x=(127,0), y=(127,0) ×4 → out_max=255.
- Stalls: m_axis_tvalid toggled 1/0 each cycle → same results as the continuous case, with the pulse delayed accordingly.

Source files
------------

// File: rtl/x_corr_if.sv
// Sample/result bundle for one correlator bin.
// master drives samples and session enable; slave is the correlator.
interface x_corr_if #(
  parameter int xi_bits             = 8,
  parameter int xq_bits             = 8,
  parameter int yi_bits             = 8,
  parameter int yq_bits             = 8,
  parameter int length_counter_bits = 3,
  parameter int out_max_bits        = 32
);
  logic signed [xi_bits-1:0]  xi;
  logic signed [xq_bits-1:0]  xq;
  logic signed [yi_bits-1:0]  yi;
  logic signed [yq_bits-1:0]  yq;
  logic                       m_axis_tvalid;
  logic                       s_axis_tready;
  logic                       m_axis_tready;
  logic                       s_axis_tvalid;
  logic [out_max_bits-1:0]    out_max;
  logic [length_counter_bits-1:0] index;

  modport master (
    output xi, xq, yi, yq,
    output m_axis_tvalid, m_axis_tready,
    input  s_axis_tready, s_axis_tvalid,
    input  out_max, index
  );

  modport slave (
    input  xi, xq, yi, yq,
    input  m_axis_tvalid, m_axis_tready,
    output s_axis_tready, s_axis_tvalid,
    output out_max, index
  );
endinterface

// File: rtl/x_corr.sv
// Streaming complex cross-correlator: x * conj(y) integrated per
// window, |sum|^2 per window, running max and its window number.
module x_corr #(
  parameter int xi_bits             = 8,
  parameter int xq_bits             = 8,
  parameter int yi_bits             = 8,
  parameter int yq_bits             = 8,
  parameter int i_bits              = 24,
  parameter int q_bits              = 24,
  parameter int length              = 8,
  parameter int length_counter_bits = 3,
  parameter int out_max_bits        = 32
) (
  input logic   clk,
  input logic   rst,
  x_corr_if.slave bus
);
  localparam int LCB = length_counter_bits;
  localparam int OB  = out_max_bits;

  localparam int PIA = xi_bits + yi_bits;
  localparam int PIB = xq_bits + yq_bits;
  localparam int PIW = ((PIA > PIB) ? PIA : PIB) + 1;
  localparam int PQA = xq_bits + yi_bits;
  localparam int PQB = xi_bits + yq_bits;
  localparam int PQW = ((PQA > PQB) ? PQA : PQB) + 1;

  localparam int SQI = 2 * i_bits;
  localparam int SQQ = 2 * q_bits;
  localparam int MFW = ((SQI > SQQ) ? SQI : SQQ) + 1;
  localparam int MW  = (MFW > OB) ? MFW : OB;

  localparam logic [LCB-1:0] LAST = LCB'(length - 1);
  localparam logic [LCB-1:0] ONE  = LCB'(1);

  logic ready;
  logic accept;

  assign ready  = bus.m_axis_tready & ~rst;
  assign accept = bus.m_axis_tvalid & ready;

  // product stage
  logic signed [PIW-1:0]    pi_full;
  logic signed [PQW-1:0]    pq_full;
  logic signed [i_bits-1:0] p_i_d;
  logic signed [q_bits-1:0] p_q_d;
  logic signed [i_bits-1:0] p_i_q;
  logic signed [q_bits-1:0] p_q_q;
  logic                     p_v_q;
  logic                     p_first_q;
  logic                     p_last_q;
  logic [LCB-1:0]           cnt_q;

  // accumulate / result stage
  logic signed [i_bits-1:0] acc_i_q;
  logic signed [q_bits-1:0] acc_q_q;
  logic signed [i_bits-1:0] sum_i_d;
  logic signed [q_bits-1:0] sum_q_d;
  logic signed [i_bits-1:0] r_i_q;
  logic signed [q_bits-1:0] r_q_q;
  logic                     r_v_q;

  // magnitude / tracking stage
  logic signed [SQI-1:0]    re2;
  logic signed [SQQ-1:0]    im2;
  logic [MFW-1:0]           mag_full;
  logic [MW-1:0]            mag_ext;
  logic [MW-1:0]            mag_lim;
  logic [OB-1:0]            mag_d;
  logic [OB-1:0]            mag_q;
  logic                     m_v_q;
  logic [LCB-1:0]           win_q;
  logic [OB-1:0]            max_q;
  logic [LCB-1:0]           idx_q;
  logic                     tvalid_q;

  // full-precision x * conj(y), then fit to accumulator widths
  always_comb begin
    pi_full = PIW'(bus.xi) * PIW'(bus.yi)
            + PIW'(bus.xq) * PIW'(bus.yq);
    pq_full = PQW'(bus.xq) * PQW'(bus.yi)
            - PQW'(bus.xi) * PQW'(bus.yq);
    p_i_d   = i_bits'(pi_full);
    p_q_d   = q_bits'(pq_full);
  end

  // register product on accept and advance the sample counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_i_q     <= '0;
      p_q_q     <= '0;
      p_v_q     <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      cnt_q     <= '0;
    end else if (!bus.m_axis_tready) begin
      p_v_q     <= 1'b0;
      p_first_q <= 1'b0;
      p_last_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      p_v_q <= accept;
      if (accept) begin
        p_i_q     <= p_i_d;
        p_q_q     <= p_q_d;
        p_first_q <= (cnt_q == '0);
        p_last_q  <= (cnt_q == LAST);
        cnt_q     <= (cnt_q == LAST) ? '0 : cnt_q + ONE;
      end
    end
  end

  // first product of a window loads, later ones add (wrapping)
  always_comb begin
    if (p_first_q) begin
      sum_i_d = p_i_q;
      sum_q_d = p_q_q;
    end else begin
      sum_i_d = acc_i_q + p_i_q;
      sum_q_d = acc_q_q + p_q_q;
    end
  end

  // integrate; the closing sum goes straight to the result register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      r_i_q   <= '0;
      r_q_q   <= '0;
      r_v_q   <= 1'b0;
    end else if (!bus.m_axis_tready) begin
      acc_i_q <= '0;
      acc_q_q <= '0;
      r_v_q   <= 1'b0;
    end else begin
      r_v_q <= p_v_q & p_last_q;
      if (p_v_q) begin
        acc_i_q <= sum_i_d;
        acc_q_q <= sum_q_d;
        if (p_last_q) begin
          r_i_q <= sum_i_d;
          r_q_q <= sum_q_d;
        end
      end
    end
  end

  // squared magnitude at full width, saturated to the output width
  always_comb begin
    re2      = SQI'(r_i_q) * SQI'(r_i_q);
    im2      = SQQ'(r_q_q) * SQQ'(r_q_q);
    mag_full = MFW'($unsigned(re2)) + MFW'($unsigned(im2));
    mag_ext  = MW'(mag_full);
    mag_lim  = MW'({OB{1'b1}});
    mag_d    = (mag_ext > mag_lim) ? {OB{1'b1}} : OB'(mag_ext);
  end

  // magnitude register, max tracking and window numbering
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mag_q    <= '0;
      m_v_q    <= 1'b0;
      win_q    <= '0;
      max_q    <= '0;
      idx_q    <= '0;
      tvalid_q <= 1'b0;
    end else if (!bus.m_axis_tready) begin
      m_v_q    <= 1'b0;
      win_q    <= '0;
      tvalid_q <= 1'b0;
    end else begin
      m_v_q    <= r_v_q;
      tvalid_q <= m_v_q;
      if (r_v_q) begin
        mag_q <= mag_d;
      end
      if (m_v_q) begin
        if ((win_q == '0) || (mag_q > max_q)) begin
          max_q <= mag_q;
          idx_q <= win_q;
        end
        win_q <= win_q + ONE;
      end
    end
  end

  assign bus.s_axis_tready = ready;
  assign bus.s_axis_tvalid = tvalid_q;
  assign bus.out_max       = max_q;
  assign bus.index         = idx_q;
endmodule

// File: tb/tb_x_corr.sv
// Directed bench for x_corr: windows of 4, a 32-bit main instance
// and an 8-bit-output instance sharing the same stimulus.
module tb_x_corr;
  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   failures;

  x_corr_if #(.length_counter_bits(3), .out_max_bits(32)) mif ();
  x_corr_if #(.length_counter_bits(3), .out_max_bits(8))  sif ();

  x_corr #(.length(4), .length_counter_bits(3), .out_max_bits(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (mif.slave)
  );

  x_corr #(.length(4), .length_counter_bits(3), .out_max_bits(8)) dut_sat (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  assign sif.xi            = mif.xi;
  assign sif.xq            = mif.xq;
  assign sif.yi            = mif.yi;
  assign sif.yq            = mif.yq;
  assign sif.m_axis_tvalid = mif.m_axis_tvalid;
  assign sif.m_axis_tready = mif.m_axis_tready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  int          pc[$];
  logic [63:0] pm[$];
  logic [63:0] px[$];
  logic [63:0] ps[$];

  always @(negedge clk) begin
    if (mif.s_axis_tvalid) begin
      pc.push_back(cyc);
      pm.push_back(64'(mif.out_max));
      px.push_back(64'(mif.index));
      ps.push_back(64'(sif.out_max));
    end
  end

  int last_acc;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr_q();
    pc.delete();
    pm.delete();
    px.delete();
    ps.delete();
  endtask

  task automatic send(input int a, input int b, input int c,
                      input int d, input bit gap);
    mif.xi = a[7:0];
    mif.xq = b[7:0];
    mif.yi = c[7:0];
    mif.yq = d[7:0];
    mif.m_axis_tvalid = 1'b1;
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (gap) begin
      mif.m_axis_tvalid = 1'b0;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic win(input int a, input int b, input int c,
                     input int d, input bit gap);
    for (int i = 0; i < 4; i++) send(a, b, c, d, gap);
  endtask

  task automatic idle(input int n);
    mif.m_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_p(input int k, input logic [63:0] em,
                       input logic [63:0] ei, input int ec);
    if (k < pc.size()) begin
      chk("pulse_max", pm[k], em);
      chk("pulse_idx", px[k], ei);
      chk("pulse_cyc", 64'(pc[k]), 64'(ec));
    end else begin
      chk("pulse_count", 64'(pc.size()), 64'(k + 1));
    end
  endtask

  task automatic new_session(input logic [63:0] hm,
                             input logic [63:0] hi);
    idle(1);
    mif.m_axis_tready = 1'b0;
    #1;
    chk("tready_low", 64'(mif.s_axis_tready), 64'd0);
    @(posedge clk);
    #1;
    chk("held_max", 64'(mif.out_max), hm);
    chk("held_idx", 64'(mif.index), hi);
    mif.m_axis_tready = 1'b1;
    clr_q();
  endtask

  int la0;

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst      = 1'b1;
    mif.xi = '0;
    mif.xq = '0;
    mif.yi = '0;
    mif.yq = '0;
    mif.m_axis_tvalid = 1'b0;
    mif.m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_max", 64'(mif.out_max), 64'd0);
    chk("rst_idx", 64'(mif.index), 64'd0);
    chk("rst_tready", 64'(mif.s_axis_tready), 64'd0);
    chk("rst_tvalid", 64'(mif.s_axis_tvalid), 64'd0);
    rst = 1'b0;
    #1;
    chk("tready_up", 64'(mif.s_axis_tready), 64'd1);
    @(posedge clk);
    #1;

    // three back-to-back windows
    clr_q();
    win(1, 0, 1, 0, 1'b0);
    la0 = last_acc;
    win(1, 0, 2, 0, 1'b0);
    win(1, 0, 1, 0, 1'b0);
    idle(6);
    chk("b2b_count", 64'(pc.size()), 64'd3);
    chk_p(0, 64'd16, 64'd0, la0 + 3);
    chk_p(1, 64'd64, 64'd1, la0 + 7);
    chk_p(2, 64'd64, 64'd1, la0 + 11);

    // conjugate: pq path, then equal magnitude keeps index 0
    new_session(64'd64, 64'd1);
    win(0, 1, 1, 0, 1'b0);
    la0 = last_acc;
    win(0, 1, 0, 1, 1'b0);
    idle(6);
    chk("conj_count", 64'(pc.size()), 64'd2);
    chk_p(0, 64'd16, 64'd0, la0 + 3);
    chk_p(1, 64'd16, 64'd0, la0 + 7);

    // negative real product
    new_session(64'd16, 64'd0);
    win(-3, 0, 2, 0, 1'b0);
    la0 = last_acc;
    idle(6);
    chk_p(0, 64'd576, 64'd0, la0 + 3);

    // partial window discarded by session drop
    new_session(64'd576, 64'd0);
    send(1, 0, 3, 0, 1'b0);
    send(1, 0, 3, 0, 1'b0);
    new_session(64'd576, 64'd0);
    win(1, 0, 1, 0, 1'b0);
    la0 = last_acc;
    idle(6);
    chk("part_count", 64'(pc.size()), 64'd1);
    chk_p(0, 64'd16, 64'd0, la0 + 3);

    // valid toggling every cycle
    new_session(64'd16, 64'd0);
    win(1, 0, 1, 0, 1'b1);
    la0 = last_acc;
    win(1, 0, 2, 0, 1'b1);
    idle(6);
    chk("stall_count", 64'(pc.size()), 64'd2);
    chk_p(0, 64'd16, 64'd0, la0 + 3);
    chk_p(1, 64'd64, 64'd1, last_acc + 3);

    // large magnitude: exact at 32 bits, saturated at 8 bits
    new_session(64'd64, 64'd1);
    win(127, 0, 127, 0, 1'b0);
    la0 = last_acc;
    idle(6);
    chk_p(0, 64'd4162314256, 64'd0, la0 + 3);
    if (ps.size() > 0) chk("sat_max", ps[0], 64'd255);
    else chk("sat_count", 64'(ps.size()), 64'd1);

    // reset in the middle of a window
    clr_q();
    send(1, 0, 3, 0, 1'b0);
    send(1, 0, 3, 0, 1'b0);
    mif.m_axis_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("mrst_max", 64'(mif.out_max), 64'd0);
    chk("mrst_idx", 64'(mif.index), 64'd0);
    chk("mrst_tready", 64'(mif.s_axis_tready), 64'd0);
    chk("mrst_sat", 64'(sif.out_max), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    win(1, 0, 1, 0, 1'b0);
    la0 = last_acc;
    idle(6);
    chk("post_rst_count", 64'(pc.size()), 64'd1);
    chk_p(0, 64'd16, 64'd0, la0 + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
